// File: rtl/dcache_main_pipe_resp_router_pkg.sv
// Shared definitions for the DCache main-pipe response return path.
// Holds the source codes, the miss-id width and the atomics response entry layout.
package dcache_resp_pkg;

  // Source codes carried with a main-pipe response.
  localparam logic [3:0] SRC_MISS    = 4'h0;
  localparam logic [3:0] SRC_REPLACE = 4'h1;
  localparam logic [3:0] SRC_AMO     = 4'h2;

  localparam int MISS_ID_W   = 2;
  localparam int RESP_DATA_W = 64;

  // One buffered atomics response. The FIFO stores the same bit layout
  // {data, error, replay} as a flat vector so that other data widths still work.
  typedef struct packed {
    logic [RESP_DATA_W-1:0] data;
    logic                   error;
    logic                   replay;
  } amo_resp_entry_t;

endpackage

// File: rtl/dcache_main_pipe_resp_router_if.sv
// Bus bundle between the main pipe, miss queue, atomics unit and the router.
// The slave modport is the router's view; the master modport is its environment.
interface dcache_main_pipe_resp_router_if
  import dcache_resp_pkg::*;
#(
  parameter int AMO_FIFO_DEPTH = 2,
  parameter int DATA_W         = 64
);
  localparam int CNT_W = $clog2(AMO_FIFO_DEPTH + 1);

  logic                 amo_req_fire;
  logic                 amo_req_allow;
  logic                 pipe_resp_valid;
  logic                 pipe_resp_ready;
  logic [3:0]           pipe_resp_source;
  logic [MISS_ID_W-1:0] pipe_resp_miss_id;
  logic [DATA_W-1:0]    pipe_resp_data;
  logic                 pipe_resp_error;
  logic                 pipe_resp_replay;
  logic                 miss_resp_valid;
  logic [MISS_ID_W-1:0] miss_resp_id;
  logic                 miss_resp_error;
  logic                 amo_resp_valid;
  logic                 amo_resp_ready;
  logic [DATA_W-1:0]    amo_resp_data;
  logic                 amo_resp_error;
  logic                 amo_resp_replay;
  logic [CNT_W-1:0]     amo_outstanding;
  logic                 err_unexpected_amo;

  modport slave (
    input  amo_req_fire, pipe_resp_valid, pipe_resp_source, pipe_resp_miss_id,
           pipe_resp_data, pipe_resp_error, pipe_resp_replay, amo_resp_ready,
    output amo_req_allow, pipe_resp_ready, miss_resp_valid, miss_resp_id,
           miss_resp_error, amo_resp_valid, amo_resp_data, amo_resp_error,
           amo_resp_replay, amo_outstanding, err_unexpected_amo
  );

  modport master (
    output amo_req_fire, pipe_resp_valid, pipe_resp_source, pipe_resp_miss_id,
           pipe_resp_data, pipe_resp_error, pipe_resp_replay, amo_resp_ready,
    input  amo_req_allow, pipe_resp_ready, miss_resp_valid, miss_resp_id,
           miss_resp_error, amo_resp_valid, amo_resp_data, amo_resp_error,
           amo_resp_replay, amo_outstanding, err_unexpected_amo
  );

endinterface

// File: rtl/dcache_main_pipe_resp_router_fifo.sv
// Small synchronous FIFO with a count register for full/empty.
// Push is ignored when full and pop is ignored when empty, so callers may
// present both freely. The head entry is visible the cycle after it is pushed.
module resp_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
    mem_d     = mem_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data;
    end else begin
      mem_d = mem_q;
    end
    wr_ptr_d = push_ok_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_ok_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset empties the buffer and zeroes storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dcache_main_pipe_resp_router.sv
// Routes main-pipe responses back to their originator: miss responses leave
// as a registered one-cycle pulse, atomics responses are buffered in a FIFO.
// Atomics issue is credit-gated so that every outstanding request always has
// a free FIFO slot waiting for its response.
module dcache_main_pipe_resp_router
  import dcache_resp_pkg::*;
#(
  parameter int         AMO_FIFO_DEPTH = 2,
  parameter int         DATA_W         = 64,
  parameter logic [3:0] SRC_AMO        = 4'h2
) (
  input logic                           clock,
  input logic                           reset,
  dcache_main_pipe_resp_router_if.slave bus
);

  localparam int CNT_W   = $clog2(AMO_FIFO_DEPTH + 1);
  localparam int ENTRY_W = DATA_W + 2;

  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  logic                 err_q, err_d;
  logic                 miss_valid_q, miss_valid_d;
  logic [MISS_ID_W-1:0] miss_id_q, miss_id_d;
  logic                 miss_err_q, miss_err_d;

  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [CNT_W-1:0]     fifo_count_s;
  logic [ENTRY_W-1:0]   fifo_head_s;
  logic [ENTRY_W-1:0]   push_entry_s;
  logic                 pipe_ready_s;
  logic                 accept_s;
  logic                 is_amo_s;
  logic                 amo_push_s;
  logic                 amo_drop_s;
  logic                 miss_acc_s;
  logic                 allow_s;
  logic                 fire_ok_s;
  logic                 fire_bad_s;
  logic                 amo_pop_s;

  // Response classification, credit accounting and next-state of the outputs.
  always_comb begin
    pipe_ready_s = ~fifo_full_s;
    accept_s     = bus.pipe_resp_valid & pipe_ready_s;
    is_amo_s     = (bus.pipe_resp_source == SRC_AMO);
    amo_push_s   = accept_s & is_amo_s & (outstanding_q != {CNT_W{1'b0}});
    amo_drop_s   = accept_s & is_amo_s & (outstanding_q == {CNT_W{1'b0}});
    miss_acc_s   = accept_s & ~is_amo_s;
    allow_s      = ({1'b0, outstanding_q} + {1'b0, fifo_count_s}) < (CNT_W+1)'(AMO_FIFO_DEPTH);
    fire_ok_s    = bus.amo_req_fire & allow_s;
    fire_bad_s   = bus.amo_req_fire & ~allow_s;
    amo_pop_s    = ~fifo_empty_s & bus.amo_resp_ready;
    push_entry_s = {bus.pipe_resp_data, bus.pipe_resp_error, bus.pipe_resp_replay};

    case ({fire_ok_s, amo_push_s})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    err_d        = err_q | amo_drop_s | fire_bad_s;
    miss_valid_d = miss_acc_s;
    miss_id_d    = miss_acc_s ? bus.pipe_resp_miss_id : {MISS_ID_W{1'b0}};
    miss_err_d   = miss_acc_s & bus.pipe_resp_error;
  end

  // Credit counter, sticky protocol error and the miss-response pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outstanding_q <= '0;
      err_q         <= 1'b0;
      miss_valid_q  <= 1'b0;
      miss_id_q     <= '0;
      miss_err_q    <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      miss_valid_q  <= miss_valid_d;
      miss_id_q     <= miss_id_d;
      miss_err_q    <= miss_err_d;
    end
  end

  resp_sync_fifo #(
    .DEPTH (AMO_FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_amo_fifo (
    .clk       (clock),
    .rst_n     (reset),
    .push      (amo_push_s),
    .push_data (push_entry_s),
    .pop       (amo_pop_s),
    .head_data (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign bus.pipe_resp_ready    = pipe_ready_s;
  assign bus.amo_req_allow      = allow_s;
  assign bus.amo_outstanding    = outstanding_q;
  assign bus.err_unexpected_amo = err_q;
  assign bus.miss_resp_valid    = miss_valid_q;
  assign bus.miss_resp_id       = miss_id_q;
  assign bus.miss_resp_error    = miss_err_q;
  assign bus.amo_resp_valid     = ~fifo_empty_s;
  assign bus.amo_resp_data      = fifo_head_s[ENTRY_W-1:2];
  assign bus.amo_resp_error     = fifo_head_s[1];
  assign bus.amo_resp_replay    = fifo_head_s[0];

endmodule

// File: tb/tb_dcache_main_pipe_resp_router.sv
// Bench for dcache_main_pipe_resp_router: directed scenarios followed by
// random traffic, all compared every cycle against a queue-based model.
module tb_dcache_main_pipe_resp_router;
  import dcache_resp_pkg::*;

  localparam int DEPTH = 2;
  localparam int DW    = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dcache_main_pipe_resp_router_if #(.AMO_FIFO_DEPTH(DEPTH), .DATA_W(DW)) bus ();

  dcache_main_pipe_resp_router #(
    .AMO_FIFO_DEPTH (DEPTH),
    .DATA_W         (DW),
    .SRC_AMO        (4'h2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: buffered AMO entries {data,error,replay}, credits, flags.
  logic [DW+1:0] m_q[$];
  int            m_outst = 0;
  bit            m_err   = 1'b0;
  bit            m_mv    = 1'b0;
  logic [1:0]    m_mid   = 2'd0;
  bit            m_merr  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_outst = 0;
    m_err   = 1'b0;
    m_mv    = 1'b0;
  endtask

  task automatic check_all();
    chk("pipe_resp_ready", 64'(bus.pipe_resp_ready), 64'(m_q.size() < DEPTH));
    chk("amo_req_allow", 64'(bus.amo_req_allow), 64'((m_outst + m_q.size()) < DEPTH));
    chk("amo_resp_valid", 64'(bus.amo_resp_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("amo_resp_data", bus.amo_resp_data, m_q[0][DW+1:2]);
      chk("amo_resp_error", 64'(bus.amo_resp_error), 64'(m_q[0][1]));
      chk("amo_resp_replay", 64'(bus.amo_resp_replay), 64'(m_q[0][0]));
    end
    chk("amo_outstanding", 64'(bus.amo_outstanding), 64'(m_outst));
    chk("err_unexpected_amo", 64'(bus.err_unexpected_amo), 64'(m_err));
    chk("miss_resp_valid", 64'(bus.miss_resp_valid), 64'(m_mv));
    if (m_mv) begin
      chk("miss_resp_id", 64'(bus.miss_resp_id), 64'(m_mid));
      chk("miss_resp_error", 64'(bus.miss_resp_error), 64'(m_merr));
    end
  endtask

  // Check, clock once, advance the model with the inputs seen at the edge.
  task automatic step();
    bit rdy, alw, acc;
    check_all();
    @(posedge clock);
    rdy = (m_q.size() < DEPTH);
    alw = ((m_outst + m_q.size()) < DEPTH);
    acc = bus.pipe_resp_valid && rdy;
    if (m_q.size() > 0 && bus.amo_resp_ready) void'(m_q.pop_front());
    m_mv = 1'b0;
    if (acc) begin
      if (bus.pipe_resp_source == SRC_AMO) begin
        if (m_outst == 0) m_err = 1'b1;
        else begin
          m_q.push_back({bus.pipe_resp_data, bus.pipe_resp_error, bus.pipe_resp_replay});
          m_outst--;
        end
      end else begin
        m_mv   = 1'b1;
        m_mid  = bus.pipe_resp_miss_id;
        m_merr = bus.pipe_resp_error;
      end
    end
    if (bus.amo_req_fire) begin
      if (alw) m_outst++;
      else m_err = 1'b1;
    end
    @(negedge clock);
  endtask

  task automatic idle();
    bus.amo_req_fire      = 1'b0;
    bus.pipe_resp_valid   = 1'b0;
    bus.pipe_resp_source  = 4'h0;
    bus.pipe_resp_miss_id = 2'd0;
    bus.pipe_resp_data    = 64'h0;
    bus.pipe_resp_error   = 1'b0;
    bus.pipe_resp_replay  = 1'b0;
    bus.amo_resp_ready    = 1'b0;
  endtask

  task automatic drive_resp(input logic [3:0] src, input logic [1:0] id,
                            input logic [63:0] data, input logic err, input logic rep);
    bus.pipe_resp_valid   = 1'b1;
    bus.pipe_resp_source  = src;
    bus.pipe_resp_miss_id = id;
    bus.pipe_resp_data    = data;
    bus.pipe_resp_error   = err;
    bus.pipe_resp_replay  = rep;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    model_clear();
    check_all();
    chk("reset_amo_resp_data", bus.amo_resp_data, 64'h0);
    reset = 1'b1;
    step();
  endtask

  initial begin
    bit         alw_m;
    logic [1:0] r;
    idle();
    do_reset();

    // Miss routing: one registered pulse with id and error.
    drive_resp(4'h0, 2'd3, 64'h0, 1'b1, 1'b0);
    step(); idle();
    chk("miss_pulse_valid", 64'(bus.miss_resp_valid), 64'd1);
    chk("miss_pulse_id", 64'(bus.miss_resp_id), 64'd3);
    chk("miss_pulse_error", 64'(bus.miss_resp_error), 64'd1);
    chk("miss_no_amo_valid", 64'(bus.amo_resp_valid), 64'd0);
    step();
    chk("miss_pulse_width", 64'(bus.miss_resp_valid), 64'd0);

    // AMO round trip.
    bus.amo_req_fire = 1'b1; step(); idle();
    chk("rt_outstanding_1", 64'(bus.amo_outstanding), 64'd1);
    drive_resp(SRC_AMO, 2'd0, 64'hDEADBEEF_00000001, 1'b0, 1'b0);
    step(); idle();
    chk("rt_outstanding_0", 64'(bus.amo_outstanding), 64'd0);
    chk("rt_valid", 64'(bus.amo_resp_valid), 64'd1);
    chk("rt_data", bus.amo_resp_data, 64'hDEADBEEF_00000001);
    bus.amo_resp_ready = 1'b1; step(); idle();
    chk("rt_popped", 64'(bus.amo_resp_valid), 64'd0);

    // Credit gating.
    bus.amo_req_fire = 1'b1; step(); step(); idle();
    chk("cg_allow_0", 64'(bus.amo_req_allow), 64'd0);
    drive_resp(SRC_AMO, 2'd0, 64'h5, 1'b0, 1'b0); step(); idle();
    chk("cg_allow_still_0", 64'(bus.amo_req_allow), 64'd0);
    chk("cg_outstanding_1", 64'(bus.amo_outstanding), 64'd1);
    bus.amo_resp_ready = 1'b1; step(); idle();
    chk("cg_allow_1", 64'(bus.amo_req_allow), 64'd1);
    drive_resp(SRC_AMO, 2'd0, 64'h6, 1'b0, 1'b0); step(); idle();
    bus.amo_resp_ready = 1'b1; step(); idle();

    // Full FIFO ordering and backpressure.
    bus.amo_req_fire = 1'b1; step(); step(); idle();
    drive_resp(SRC_AMO, 2'd0, 64'h11, 1'b0, 1'b0); step();
    drive_resp(SRC_AMO, 2'd0, 64'h22, 1'b0, 1'b0); step(); idle();
    chk("full_ready_0", 64'(bus.pipe_resp_ready), 64'd0);
    bus.amo_resp_ready = 1'b1;
    chk("full_head_first", bus.amo_resp_data, 64'h11);
    step();
    chk("full_head_second", bus.amo_resp_data, 64'h22);
    step(); idle();
    chk("full_drained_valid", 64'(bus.amo_resp_valid), 64'd0);
    chk("full_ready_back", 64'(bus.pipe_resp_ready), 64'd1);

    // Unexpected AMO response with no credit outstanding.
    drive_resp(SRC_AMO, 2'd0, 64'h99, 1'b0, 1'b0); step(); idle();
    chk("unexp_err_set", 64'(bus.err_unexpected_amo), 64'd1);
    chk("unexp_fifo_empty", 64'(bus.amo_resp_valid), 64'd0);
    step(); step();
    chk("unexp_err_sticky", 64'(bus.err_unexpected_amo), 64'd1);
    do_reset();

    // Replay is forwarded and does not restore a credit.
    bus.amo_req_fire = 1'b1; step(); idle();
    drive_resp(SRC_AMO, 2'd0, 64'h77, 1'b1, 1'b1); step(); idle();
    chk("replay_flag", 64'(bus.amo_resp_replay), 64'd1);
    bus.amo_resp_ready = 1'b1; step(); idle();
    chk("replay_no_credit", 64'(bus.amo_outstanding), 64'd0);

    // Asynchronous reset between clock edges.
    bus.amo_req_fire = 1'b1; step(); step(); idle();
    drive_resp(SRC_AMO, 2'd0, 64'hAB, 1'b0, 1'b0); step(); idle();
    chk("ar_pre_valid", 64'(bus.amo_resp_valid), 64'd1);
    chk("ar_pre_outstanding", 64'(bus.amo_outstanding), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid_clear", 64'(bus.amo_resp_valid), 64'd0);
    chk("ar_outstanding_clear", 64'(bus.amo_outstanding), 64'd0);
    chk("ar_ready", 64'(bus.pipe_resp_ready), 64'd1);
    chk("ar_allow", 64'(bus.amo_req_allow), 64'd1);
    chk("ar_data_clear", bus.amo_resp_data, 64'h0);
    model_clear();
    @(negedge clock);
    reset = 1'b1;
    step();
    chk("ar_post_allow", 64'(bus.amo_req_allow), 64'd1);
    chk("ar_post_valid", 64'(bus.amo_resp_valid), 64'd0);

    // Random traffic against the model, with periodic resets.
    for (int i = 0; i < 400; i++) begin
      alw_m = ((m_outst + m_q.size()) < DEPTH);
      bus.amo_req_fire = ($urandom_range(0, 49) == 0) ? 1'b1 : (alw_m && $urandom_range(0, 1) == 1);
      r = 2'($urandom_range(0, 3));
      drive_resp((r < 2'd2) ? SRC_AMO : 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bus.pipe_resp_valid = 1'($urandom_range(0, 1));
      bus.amo_resp_ready  = 1'($urandom_range(0, 1));
      step();
      if (i % 100 == 99) do_reset();
    end
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_main_pipe_resp_router.md
Name: dcache_main_pipe_resp_router

Overview:
Return path of the DCache main-pipe request arbiter. It takes main-pipe responses and routes each one back to its originator: a miss-queue entry or the atomics unit.
- Miss responses leave as a one-cycle registered pulse tagged with the miss id.
- Atomics responses are buffered in a small FIFO with valid/ready toward the atomics unit.
- Atomics issue is credit-gated so the FIFO can never overflow.

Parameters:
AMO_FIFO_DEPTH, 2, atomics response FIFO entries (power of two, >=2)
DATA_W, 64, response data width
SRC_AMO, 4'h2, source encoding that identifies an atomics response

Ports:
clock  input  1  core clock
reset  input  1  asynchronous, active-low reset
amo_req_fire  input  1  atomics request accepted by arbiter (in_1 valid&ready)
amo_req_allow  output  1  atomics unit may raise its request valid
pipe_resp_valid  input  1  main-pipe response valid
pipe_resp_ready  output  1  router can accept a response
pipe_resp_source  input  4  originator source code
pipe_resp_miss_id  input  2  miss-queue entry id (miss responses only)
pipe_resp_data  input  DATA_W  load/AMO result data
pipe_resp_error  input  1  ECC/bus error
pipe_resp_replay  input  1  request must be reissued
miss_resp_valid  output  1  one-cycle pulse to miss queue
miss_resp_id  output  2  target miss entry
miss_resp_error  output  1  error flag for miss entry
amo_resp_valid  output  1  FIFO head valid
amo_resp_ready  input  1  atomics unit accepts head
amo_resp_data  output  DATA_W  head data
amo_resp_error  output  1  head error
amo_resp_replay  output  1  head replay
amo_outstanding  output  $clog2(AMO_FIFO_DEPTH+1)  atomics issued, response not yet received
err_unexpected_amo  output  1  sticky protocol error

Behaviour:
- Reset: all outputs 0 except pipe_resp_ready=1 and amo_req_allow=1. FIFO empty, counters 0, sticky error cleared. Reset mid-operation discards buffered responses and outstanding credits.
- Accept: a response is accepted when pipe_resp_valid & pipe_resp_ready.
- pipe_resp_ready = !fifo_full. This is a combinational function of registered state only.
- Classification: source==SRC_AMO selects the AMO path; any other source selects the miss path.
- Miss path: miss_resp_valid/id/error are registered, one cycle after accept. Pulse width is one cycle; no backpressure.
- AMO path:
  - If amo_outstanding==0: drop the response, set err_unexpected_amo (sticky until reset), leave the FIFO unchanged.
  - Otherwise: push {data,error,replay} into the FIFO and decrement amo_outstanding in the same cycle.
  - A replayed response is forwarded with amo_resp_replay=1; it does not re-credit on its own.
- FIFO:
  - amo_resp_* is driven from the head entry, so data is visible the cycle after push.
  - Pop on amo_resp_valid & amo_resp_ready.
  - Push and pop in the same cycle when full: push is blocked by ready=0 and the pop proceeds.
  - Push and pop in the same cycle when non-full: count unchanged.
  - Pointers are log2(AMO_FIFO_DEPTH) bits and wrap naturally; full/empty use a count register.
- Credits:
  - amo_outstanding += amo_req_fire; amo_outstanding -= (accepted AMO response).
  - Simultaneous increment and decrement leaves it unchanged.
  - amo_req_allow = (amo_outstanding + fifo_count) < AMO_FIFO_DEPTH, computed from registered values.
  - amo_req_fire while allow==0 is a protocol violation: saturate (no increment) and set err_unexpected_amo.

Decomposition:
- Shared package dcache_resp_pkg: SRC_AMO and the other source codes, the miss-id width, and a packed amo_resp_entry_t {data, error, replay}.
- One sub-module: resp_sync_fifo (parameterised depth/width, push/pop/full/empty/count), reused for the AMO buffer.

Test Plan:
- Miss routing: accept source=0, miss_id=3, error=1 → next cycle miss_resp_valid=1, id=3, error=1 for exactly one cycle; amo_resp_valid stays 0.
- AMO round-trip: amo_req_fire → outstanding=1 → response source=2, data=0xDEADBEEF_00000001 → outstanding=0; next cycle amo_resp_valid=1 with that data; ready=1 pops and valid=0.
- Credit gating: two amo_req_fire with no responses → amo_req_allow=0. One response accepted with amo_resp_ready held 0 → allow still 0 (fifo_count=1, outstanding=1). After the pop → allow=1.
- Full FIFO: fill both entries with ready=0 → pipe_resp_ready=0. Assert ready=1 → pop in order (data 0x11 then 0x22) and pipe_resp_ready returns to 1.
- Unexpected response: AMO response with outstanding=0 → FIFO unchanged, err_unexpected_amo=1 and it stays 1 afterwards.
- Async reset mid-flight: FIFO holding 1 entry, outstanding=1, assert reset between clock edges → outputs clear immediately; after release, allow=1 and amo_resp_valid=0.
